// File: rtl/register_uart_reporter.sv
`default_nettype none
// ============================================================================
// Module  : register_uart_reporter
// Brief   : Sends register1Value as hex ASCII + CR LF over an 8N1 UART on change.
// Revision: 1.0  initial release
// ============================================================================
module register_uart_reporter #(
    parameter int REGISTER_WIDTH = 16,
    parameter int CLKS_PER_BIT   = 434,
    parameter int COUNT_WIDTH    = 8
) (
    input  logic                      clock,
    input  logic                      isReset,
    input  logic [REGISTER_WIDTH-1:0] register1Value,
    output logic                      txd,
    output logic                      busy,
    output logic [COUNT_WIDTH-1:0]    messagesSent
);

    localparam int c_nibbles   = REGISTER_WIDTH / 4;
    localparam int c_num_bytes = c_nibbles + 2;
    localparam int c_byte_w    = $clog2(c_num_bytes);
    localparam int c_cnt_w     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_byte_w-1:0] c_cr_idx   = c_byte_w'(c_nibbles);
    localparam logic [c_byte_w-1:0] c_last_idx = c_byte_w'(c_num_bytes - 1);
    localparam logic [c_cnt_w-1:0]  c_bit_last = c_cnt_w'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic [c_cnt_w-1:0]        r_clk_cnt;
    logic [2:0]                r_bit_idx;
    logic [c_byte_w-1:0]       r_byte_idx;
    logic [REGISTER_WIDTH-1:0] r_snapshot;
    logic [REGISTER_WIDTH-1:0] r_last_sent;
    logic                      r_force;
    logic                      r_txd;
    logic                      r_busy;
    logic [COUNT_WIDTH-1:0]    r_count;

    logic                      w_start;
    logic                      w_bit_done;
    logic [3:0]                w_nibble;
    logic [7:0]                w_byte;
    logic                      w_bit;

    assign w_start    = r_force || (register1Value != r_last_sent);
    assign w_bit_done = (r_clk_cnt == c_bit_last);

    // Character currently being framed, taken from the frozen snapshot.
    always_comb begin
        w_nibble = '0;
        for (int i = 0; i < c_nibbles; i++) begin
            if (r_byte_idx == c_byte_w'(i)) begin
                w_nibble = r_snapshot[(c_nibbles-1-i)*4 +: 4];
            end
        end
        if (r_byte_idx == c_cr_idx) begin
            w_byte = 8'h0D;
        end else if (r_byte_idx == c_last_idx) begin
            w_byte = 8'h0A;
        end else if (w_nibble < 4'd10) begin
            w_byte = 8'h30 + {4'h0, w_nibble};
        end else begin
            w_byte = 8'h37 + {4'h0, w_nibble};
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_bit        = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_next_state = S_START;
            end
            S_START: begin
                w_bit = 1'b0;
                if (w_bit_done) w_next_state = S_DATA;
            end
            S_DATA: begin
                w_bit = w_byte[r_bit_idx];
                if (w_bit_done && (r_bit_idx == 3'd7)) w_next_state = S_STOP;
            end
            S_STOP: begin
                if (w_bit_done) begin
                    w_next_state = (r_byte_idx == c_last_idx) ? S_IDLE : S_START;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge isReset) begin
        if (!isReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Line level is registered one cycle behind the state so txd is glitch-free.
    always_ff @(posedge clock or negedge isReset) begin
        if (!isReset) begin
            r_clk_cnt   <= '0;
            r_bit_idx   <= '0;
            r_byte_idx  <= '0;
            r_snapshot  <= '0;
            r_last_sent <= '0;
            r_force     <= 1'b1;
            r_txd       <= 1'b1;
            r_busy      <= 1'b0;
            r_count     <= '0;
        end else begin
            r_txd  <= w_bit;
            r_busy <= (r_state != S_IDLE);
            if ((r_state == S_IDLE) || w_bit_done) begin
                r_clk_cnt <= '0;
            end else begin
                r_clk_cnt <= r_clk_cnt + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    r_bit_idx  <= '0;
                    r_byte_idx <= '0;
                    if (w_start) begin
                        r_snapshot <= register1Value;
                        r_force    <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (w_bit_done) r_bit_idx <= r_bit_idx + 1'b1;
                end
                S_STOP: begin
                    if (w_bit_done) begin
                        if (r_byte_idx == c_last_idx) begin
                            r_last_sent <= r_snapshot;
                            r_count     <= r_count + 1'b1;
                        end else begin
                            r_byte_idx <= r_byte_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign txd          = r_txd;
    assign busy         = r_busy;
    assign messagesSent = r_count;

endmodule
`default_nettype wire
